// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file: address-width helper,
// default-geometry data/address types and the supported port-count range.
package regfile_pkg;

  localparam int unsigned MinPorts   = 1;
  localparam int unsigned MaxRdPorts = 4;
  localparam int unsigned MaxWrPorts = 3;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefNregs = 32;

  // Address bits needed for a register count; never less than one bit.
  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  typedef logic [DefXlen-1:0]                reg_data_t;
  typedef logic [addr_width(DefNregs)-1:0]   reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per architectural register, set at issue and
// cleared by writeback. Issue beats writeback on the same register in the same cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned Nregs   = 32,
  parameter int unsigned RdPorts = 2,
  parameter int unsigned WrPorts = 2,
  parameter int unsigned Bypass  = 1,
  parameter int unsigned Aw      = addr_width(Nregs)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clk_en_i,
  input  logic [WrPorts-1:0]     wr_en_i,
  input  logic [WrPorts*Aw-1:0]  wr_addr_i,
  input  logic [RdPorts*Aw-1:0]  rd_addr_i,
  input  logic                   sb_set_i,
  input  logic [Aw-1:0]          sb_set_addr_i,
  output logic [Nregs-1:0]       busy_o,
  output logic [RdPorts-1:0]     rd_busy_o
);

  logic [Nregs-1:0] busy_q;
  logic [Nregs-1:0] busy_d;
  logic [Nregs-1:0] wr_hit;

  // Decode every active write port into a per-register "written this cycle" mask.
  always_comb begin
    wr_hit = '0;
    for (int unsigned p = 0; p < WrPorts; p++) begin
      if (wr_en_i[p]) begin
        wr_hit[wr_addr_i[p*Aw +: Aw]] = 1'b1;
      end
    end
  end

  // Next busy vector: writes clear, issue sets afterwards so it wins; x0 never busy.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (sb_set_i) begin
      busy_d[sb_set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Per-read-port hazard lookup; a same-cycle write only resolves it when bypassing.
  always_comb begin
    rd_busy_o = '0;
    for (int unsigned r = 0; r < RdPorts; r++) begin
      if (rd_addr_i[r*Aw +: Aw] != '0) begin
        rd_busy_o[r] = busy_q[rd_addr_i[r*Aw +: Aw]] &
                       ~((Bypass != 0) & wr_hit[rd_addr_i[r*Aw +: Aw]]);
      end
    end
  end

  // Busy state register: reset dominates the clock enable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
    end else if (clk_en_i) begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_integer_mp.sv
// Parametrised multi-port integer register file with optional write-to-read bypass and a
// busy-bit scoreboard for issue hazards. x0 is hardwired to zero.
module regfile_integer_mp
  import regfile_pkg::*;
#(
  parameter int unsigned C_XLEN     = 32,
  parameter int unsigned C_NREGS    = 32,
  parameter int unsigned C_RD_PORTS = 2,
  parameter int unsigned C_WR_PORTS = 2,
  parameter int unsigned C_BYPASS   = 1,
  localparam int unsigned AW        = addr_width(C_NREGS)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clk_en_i,
  input  logic [C_WR_PORTS-1:0]        wr_en_i,
  input  logic [C_WR_PORTS*AW-1:0]     wr_addr_i,
  input  logic [C_WR_PORTS*C_XLEN-1:0] wr_data_i,
  input  logic [C_RD_PORTS-1:0]        rd_en_i,
  input  logic [C_RD_PORTS*AW-1:0]     rd_addr_i,
  output logic [C_RD_PORTS*C_XLEN-1:0] rd_data_o,
  output logic [C_RD_PORTS-1:0]        rd_busy_o,
  input  logic                         sb_set_i,
  input  logic [AW-1:0]                sb_set_addr_i,
  output logic [C_NREGS-1:0]           busy_o
);

  logic [C_XLEN-1:0]            regs_q [C_NREGS];
  logic [C_XLEN-1:0]            regs_d [C_NREGS];
  logic [C_RD_PORTS*C_XLEN-1:0] rd_data_q;
  logic [C_RD_PORTS*C_XLEN-1:0] rd_data_d;

  // Write-port priority mux: later ports override earlier ones; x0 is never written.
  always_comb begin
    for (int unsigned i = 0; i < C_NREGS; i++) begin
      regs_d[i] = regs_q[i];
      for (int unsigned p = 0; p < C_WR_PORTS; p++) begin
        if ((i != 0) && wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(i))) begin
          regs_d[i] = wr_data_i[p*C_XLEN +: C_XLEN];
        end
      end
    end
  end

  // Read mux: regs_d already carries the winning write, so it doubles as the bypass path.
  always_comb begin
    rd_data_d = rd_data_q;
    for (int unsigned r = 0; r < C_RD_PORTS; r++) begin
      if (rd_en_i[r]) begin
        if (rd_addr_i[r*AW +: AW] == '0) begin
          rd_data_d[r*C_XLEN +: C_XLEN] = '0;
        end else if (C_BYPASS != 0) begin
          rd_data_d[r*C_XLEN +: C_XLEN] = regs_d[rd_addr_i[r*AW +: AW]];
        end else begin
          rd_data_d[r*C_XLEN +: C_XLEN] = regs_q[rd_addr_i[r*AW +: AW]];
        end
      end
    end
  end

  // Storage and registered read data; reset dominates the clock enable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < C_NREGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else if (clk_en_i) begin
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

  regfile_scoreboard #(
    .Nregs   (C_NREGS),
    .RdPorts (C_RD_PORTS),
    .WrPorts (C_WR_PORTS),
    .Bypass  (C_BYPASS),
    .Aw      (AW)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clk_en_i      (clk_en_i),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .rd_addr_i     (rd_addr_i),
    .sb_set_i      (sb_set_i),
    .sb_set_addr_i (sb_set_addr_i),
    .busy_o        (busy_o),
    .rd_busy_o     (rd_busy_o)
  );

endmodule
